ram_pipe_reader: RTL and testbench

RAM_PIPE_READER -- requirements
Module: ram_pipe_reader

---
 rtl/ram_pipe_reader.sv | 128 ++++++++++++
 tb/tb_ram_pipe_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_pipe_reader.sv
// ram_pipe_reader: streams a burst of words out of a pipelined RAM.
// A credit counter (in-flight reads + FIFO occupancy) gates read issue so the
// output skid FIFO can never overflow, whatever the consumer does.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start with a non-zero length
//   ISSUE | issuing one read per cycle while credit is available
//   DRAIN | all reads issued, waiting for the last word to be accepted
module ram_pipe_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 18,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = FIFO_DEPTH[CNT_W:0];
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W:0]    issue_left, accept_left;
    logic [RD_LAT-1:0]  vld_sr;
    logic [CNT_W-1:0]   inflight, count;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W:0]     credit_used;
    logic               start_ok, issue, push, pop, last_issue, last_accept;

    assign start_ok    = (state == IDLE) && start && (len != '0);
    assign push        = vld_sr[RD_LAT-1];
    assign m_valid     = (count != '0);
    assign pop         = m_valid && m_ready;
    assign m_data      = fifo_mem[rd_ptr];
    // A word leaving the FIFO this cycle frees its slot for a read issued now,
    // which is what lets the minimum-depth FIFO sustain one word per cycle.
    assign credit_used = {1'b0, inflight} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
    assign issue       = (state == ISSUE) && (credit_used < DEPTH_C);
    assign last_issue  = issue && (issue_left == ONE_W);
    assign last_accept = pop && (accept_left == ONE_W);
    assign busy        = (state != IDLE);
    assign done        = (state == DRAIN) && last_accept;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)    state_nxt = ISSUE;
            ISSUE:   if (last_issue)  state_nxt = DRAIN;
            DRAIN:   if (last_accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address generation and burst down-counters (reads left, words left).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr       <= '0;
            issue_left  <= '0;
            accept_left <= '0;
        end else if (start_ok) begin
            raddr       <= base_addr;
            issue_left  <= len;
            accept_left <= len;
        end else begin
            if (issue) begin
                raddr      <= raddr + ADDR_W'(1);
                issue_left <= issue_left - ONE_W;
            end
            if (pop && (accept_left != '0))
                accept_left <= accept_left - ONE_W;
        end
    end

    // Read-valid shift register and in-flight read count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr   <= '0;
            inflight <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++)
                vld_sr[i] <= vld_sr[i-1];
            inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rdata;
    end

endmodule

// File: tb/tb_ram_pipe_reader.sv
// Directed testbench for ram_pipe_reader with a 3-cycle pipelined RAM model
// preloaded with mem[i] = i.
module tb_ram_pipe_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 18;

    logic              clk, rst, start, m_ready;
    logic [ADDR_W-1:0] base_addr, raddr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] rdata, m_data;
    logic              m_valid, busy, done;

    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] p1, p2;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int start_cyc = 0;
    int issued = 0;
    int max_out = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] done_data;
    logic              done_acc;
    logic              busy_prev = 1'b0;
    logic [ADDR_W-1:0] raddr_prev = '0;
    logic [DATA_W-1:0] rx[$];
    int                acc_cyc[$];
    logic [15:0]       lfsr;

    ram_pipe_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .raddr(raddr), .rdata(rdata), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM: address sampled at a clock edge, data valid three cycles after the
    // cycle in which the address was presented.
    always @(posedge clk) begin
        p1    <= mem[raddr];
        p2    <= p1;
        rdata <= p2;
    end

    // One clock cycle: log accepted words and done, advance, track issues.
    task automatic cyc();
        if (m_valid && m_ready) begin
            rx.push_back(m_data);
            acc_cyc.push_back(cyc_n);
        end
        if (done) begin
            done_cnt++;
            done_data = m_data;
            done_acc  = m_valid && m_ready;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (busy_prev && !rst && raddr != raddr_prev) issued++;
        busy_prev  = busy;
        raddr_prev = raddr;
        if (issued - rx.size() > max_out) max_out = issued - rx.size();
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        rx.delete();
        acc_cyc.delete();
        issued    = 0;
        max_out   = 0;
        done_cnt  = 0;
        start_cyc = cyc_n;
        base_addr = b;
        len       = l;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] got;
        for (int i = 0; i < 3; i++) cyc();
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++; if (raddr !== '0)     begin errors++; $display("FAIL reset_raddr got %h exp 000", raddr); end
        rst = 1'b0;
        start_burst(10'h005, 11'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_after_rst_busy got %b exp 1", busy); end
        m_ready = 1'b1;
        for (int i = 0; i < 40 && done_cnt == 0; i++) cyc();
        checks++; if (rx.size() !== 2) begin errors++; $display("FAIL first_burst_size got %0d exp 2", rx.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== DATA_W'(5 + i)) begin errors++; $display("FAIL first_burst_word%0d got %h exp %h", i, got, DATA_W'(5 + i)); end
        end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] got;
        int d;
        m_ready = 1'b1;
        start_burst(10'h010, 11'd8);
        for (int i = 0; i < 60 && done_cnt == 0; i++) cyc();
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (rx.size() !== 8) begin errors++; $display("FAIL basic_size got %0d exp 8", rx.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== DATA_W'(16'h10 + i)) begin errors++; $display("FAIL basic_word%0d got %h exp %h", i, got, DATA_W'(16'h10 + i)); end
        end
        d = (acc_cyc.size() > 0) ? acc_cyc[0] - start_cyc : -1;
        checks++; if (d !== 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", d); end
        d = (acc_cyc.size() == 8) ? acc_cyc[7] - acc_cyc[0] : -1;
        checks++; if (d !== 7) begin errors++; $display("FAIL basic_back_to_back span got %0d exp 7", d); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
        checks++; if (!(done_acc === 1'b1 && done_data === DATA_W'(16'h17))) begin
            errors++; $display("FAIL basic_done_word got %h acc %b exp 00017 acc 1", done_data, done_acc);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
        checks++; if (issued !== 8) begin errors++; $display("FAIL basic_issued got %0d exp 8", issued); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] exp_w [4];
        logic [DATA_W-1:0] got;
        exp_w[0] = 18'h003FE; exp_w[1] = 18'h003FF; exp_w[2] = 18'h00000; exp_w[3] = 18'h00001;
        m_ready = 1'b1;
        start_burst(10'h3FE, 11'd4);
        for (int i = 0; i < 60 && done_cnt == 0; i++) cyc();
        checks++; if (rx.size() !== 4) begin errors++; $display("FAIL wrap_size got %0d exp 4", rx.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL wrap_word%0d got %h exp %h", i, got, exp_w[i]); end
        end
        checks++; if (raddr !== 10'h002) begin errors++; $display("FAIL wrap_raddr_end got %h exp 002", raddr); end
    endtask

    task automatic test_random_ready();
        logic [DATA_W-1:0] got;
        lfsr    = 16'hACE1;
        m_ready = 1'b0;
        start_burst(10'h100, 11'd16);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            m_ready = lfsr[0];
            cyc();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (rx.size() !== 16) begin errors++; $display("FAIL random_size got %0d exp 16", rx.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== DATA_W'(16'h100 + i)) begin errors++; $display("FAIL random_word%0d got %h exp %h", i, got, DATA_W'(16'h100 + i)); end
        end
        checks++; if (max_out > 4) begin errors++; $display("FAIL random_outstanding got %0d exp <=4", max_out); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL random_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] got;
        m_ready = 1'b0;
        start_burst(10'h200, 11'd16);
        for (int i = 0; i < 20; i++) cyc();
        checks++; if (issued !== 4) begin errors++; $display("FAIL stall_issued got %0d exp 4", issued); end
        checks++; if (raddr !== 10'h204) begin errors++; $display("FAIL stall_raddr got %h exp 204", raddr); end
        checks++; if (!(m_valid === 1'b1 && m_data === 18'h00200)) begin
            errors++; $display("FAIL stall_head got valid %b data %h exp valid 1 data 00200", m_valid, m_data);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 80 && done_cnt == 0; i++) cyc();
        checks++; if (rx.size() !== 16) begin errors++; $display("FAIL stall_size got %0d exp 16", rx.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== DATA_W'(16'h200 + i)) begin errors++; $display("FAIL stall_word%0d got %h exp %h", i, got, DATA_W'(16'h200 + i)); end
        end
        checks++; if (max_out > 4) begin errors++; $display("FAIL stall_outstanding got %0d exp <=4", max_out); end
    endtask

    task automatic test_ignore();
        logic [DATA_W-1:0] got;
        m_ready = 1'b1;
        start_burst(10'h050, 11'd0);
        for (int i = 0; i < 6; i++) cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b exp 0", busy); end
        checks++; if (done_cnt !== 0 || rx.size() !== 0) begin
            errors++; $display("FAIL len0_activity got done %0d words %0d exp 0 0", done_cnt, rx.size());
        end
        start_burst(10'h040, 11'd6);
        cyc();
        cyc();
        base_addr = 10'h300;
        len       = 11'd3;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        for (int i = 0; i < 60 && done_cnt == 0; i++) cyc();
        for (int i = 0; i < 8; i++) cyc();
        checks++; if (rx.size() !== 6) begin errors++; $display("FAIL ignore_size got %0d exp 6", rx.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== DATA_W'(16'h40 + i)) begin errors++; $display("FAIL ignore_word%0d got %h exp %h", i, got, DATA_W'(16'h40 + i)); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] got;
        m_ready = 1'b1;
        start_burst(10'h080, 11'd8);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got %b exp 0", m_valid); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (raddr !== '0)     begin errors++; $display("FAIL rstmid_raddr got %h exp 000", raddr); end
        cyc();
        rst = 1'b0;
        rx.delete();
        done_cnt = 0;
        for (int i = 0; i < 15; i++) cyc();
        checks++; if (rx.size() !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL rstmid_stale got words %0d done %0d exp 0 0", rx.size(), done_cnt);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b exp 0", busy); end
        start_burst(10'h0A0, 11'd3);
        for (int i = 0; i < 40 && done_cnt == 0; i++) cyc();
        checks++; if (rx.size() !== 3) begin errors++; $display("FAIL rstmid_recover_size got %0d exp 3", rx.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rx.size()) ? rx[i] : 'x;
            checks++; if (got !== DATA_W'(16'hA0 + i)) begin errors++; $display("FAIL rstmid_recover_word%0d got %h exp %h", i, got, DATA_W'(16'hA0 + i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i);
        rst       = 1'b1;
        start     = 1'b0;
        m_ready   = 1'b0;
        base_addr = '0;
        len       = '0;
        done_data = '0;
        done_acc  = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_random_ready();
        test_stall();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
